// File: rtl/alu_sum_stage.sv
// Registered adder/result stage of the pipelined ALU: LHS + Logic + cin (or Logic pass-through), with flags.
// Define ALU_SUM_OVERFLOW_EN to build the signed-overflow flag; otherwise FlagV is tied to 0.
module alu_sum_stage (
    input  logic       AluClock,
    input  logic       nReset,
    input  logic [7:0] LHS,
    input  logic [7:0] Logic,
    input  logic       InValid,
    input  logic       OpSum,
    input  logic [1:0] CarrySel,
    input  logic       FlagWe,
    input  logic       Stall,
    output logic [7:0] Result,
    output logic       OutValid,
    output logic       FlagC,
    output logic       FlagZ,
    output logic       FlagN,
    output logic       FlagV
);

    logic       cin;
    logic [8:0] sum;
    logic [7:0] res_next;
    logic       c_next;
    logic       z_next;
    logic       n_next;
    logic       load;
    logic       flag_load;

    // cin is taken from the registered carry, so chained ADC/SBC needs no forwarding.
    always_comb begin
        cin = 1'b0;
        unique case (CarrySel)
            2'b00: cin = 1'b0;
            2'b01: cin = 1'b1;
            2'b10: cin = FlagC;
            2'b11: cin = ~FlagC;
            default: cin = 1'b0;
        endcase
    end

    always_comb begin
        sum      = {1'b0, LHS} + {1'b0, Logic} + {8'b0, cin};
        res_next = OpSum ? sum[7:0] : Logic;
        c_next   = OpSum & sum[8];
        z_next   = (res_next == 8'h00);
        n_next   = res_next[7];
        load      = ~Stall & InValid;
        flag_load = load & FlagWe;
    end

    always_ff @(posedge AluClock or negedge nReset) begin
        if (!nReset) begin
            Result   <= '0;
            OutValid <= 1'b0;
        end else if (!Stall) begin
            OutValid <= InValid;
            if (InValid)
                Result <= res_next;
        end
    end

    always_ff @(posedge AluClock or negedge nReset) begin
        if (!nReset) begin
            FlagC <= 1'b0;
            FlagZ <= 1'b0;
            FlagN <= 1'b0;
        end else if (flag_load) begin
            FlagC <= c_next;
            FlagZ <= z_next;
            FlagN <= n_next;
        end
    end

`ifdef ALU_SUM_OVERFLOW_EN
    logic v_next;

    always_comb begin
        v_next = OpSum & (LHS[7] == Logic[7]) & (res_next[7] != LHS[7]);
    end

    always_ff @(posedge AluClock or negedge nReset) begin
        if (!nReset)
            FlagV <= 1'b0;
        else if (flag_load)
            FlagV <= v_next;
    end
`else
    assign FlagV = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sum_stage.sv
// Self-checking bench for alu_sum_stage: directed vector table, stall/reset sequences, randomized model check.
module tb_alu_sum_stage;

`ifdef ALU_SUM_OVERFLOW_EN
    localparam bit V_EN = 1'b1;
`else
    localparam bit V_EN = 1'b0;
`endif

    logic       AluClock = 1'b0;
    logic       nReset;
    logic [7:0] LHS;
    logic [7:0] Logic;
    logic       InValid;
    logic       OpSum;
    logic [1:0] CarrySel;
    logic       FlagWe;
    logic       Stall;
    logic [7:0] Result;
    logic       OutValid;
    logic       FlagC;
    logic       FlagZ;
    logic       FlagN;
    logic       FlagV;

    alu_sum_stage dut (
        .AluClock(AluClock),
        .nReset  (nReset),
        .LHS     (LHS),
        .Logic   (Logic),
        .InValid (InValid),
        .OpSum   (OpSum),
        .CarrySel(CarrySel),
        .FlagWe  (FlagWe),
        .Stall   (Stall),
        .Result  (Result),
        .OutValid(OutValid),
        .FlagC   (FlagC),
        .FlagZ   (FlagZ),
        .FlagN   (FlagN),
        .FlagV   (FlagV)
    );

    always #5 AluClock = ~AluClock;

    typedef struct {
        logic [7:0] lhs;
        logic [7:0] lg;
        logic       op;
        logic [1:0] cs;
        logic       fw;
        logic       inv;
        logic [7:0] e_res;
        logic       e_val;
        logic       e_c;
        logic       e_z;
        logic       e_n;
        logic       e_v;
    } vec_t;

    vec_t tbl[9];

    int checks = 0;
    int errors = 0;

    // behavioural reference state
    int m_res;
    int m_val, m_c, m_z, m_n, m_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] r, input logic v,
                           input logic c, input logic z, input logic n, input logic ov);
        chk({tag, ".Result"}, 32'(Result), 32'(r));
        chk({tag, ".OutValid"}, 32'(OutValid), 32'(v));
        chk({tag, ".FlagC"}, 32'(FlagC), 32'(c));
        chk({tag, ".FlagZ"}, 32'(FlagZ), 32'(z));
        chk({tag, ".FlagN"}, 32'(FlagN), 32'(n));
        chk({tag, ".FlagV"}, 32'(FlagV), 32'(ov));
    endtask

    task automatic drive(input logic [7:0] lhs, input logic [7:0] lg, input logic op,
                         input logic [1:0] cs, input logic fw, input logic inv, input logic st);
        LHS = lhs; Logic = lg; OpSum = op; CarrySel = cs; FlagWe = fw; InValid = inv; Stall = st;
    endtask

    task automatic model_reset();
        m_res = 0; m_val = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    endtask

    // Next state from the arithmetic rules: unsigned sum for C, signed range for V.
    task automatic model_edge();
        int cin, s, r, ss;
        if (Stall) return;
        m_val = InValid;
        if (!InValid) return;
        case (CarrySel)
            2'd0: cin = 0;
            2'd1: cin = 1;
            2'd2: cin = m_c;
            default: cin = 1 - m_c;
        endcase
        s  = int'(LHS) + int'(Logic) + cin;
        ss = int'($signed(LHS)) + int'($signed(Logic)) + cin;
        r  = OpSum ? (s % 256) : int'(Logic);
        m_res = r;
        if (FlagWe) begin
            m_c = (OpSum && s > 255) ? 1 : 0;
            m_z = (r == 0) ? 1 : 0;
            m_n = (r >= 128) ? 1 : 0;
            m_v = (V_EN && OpSum && (ss > 127 || ss < -128)) ? 1 : 0;
        end
    endtask

    task automatic tick();
        @(posedge AluClock);
        #1;
    endtask

    initial begin
        tbl[0] = '{8'hCC, 8'hF0, 1'b1, 2'b00, 1'b1, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h05, 8'hFC, 1'b1, 2'b01, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b1, 2'b00, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, V_EN};
        tbl[3] = '{8'hFF, 8'h01, 1'b1, 2'b00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h55, 8'h00, 1'b0, 2'b01, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h55, 8'h80, 1'b0, 2'b00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'hFF, 8'h33, 1'b1, 2'b01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'h10, 8'h20, 1'b1, 2'b11, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        nReset = 1'b0;
        #12;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge AluClock);
        nReset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge AluClock);
            drive(tbl[i].lhs, tbl[i].lg, tbl[i].op, tbl[i].cs, tbl[i].fw, tbl[i].inv, 1'b0);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_res, tbl[i].e_val,
                    tbl[i].e_c, tbl[i].e_z, tbl[i].e_n, tbl[i].e_v);
        end

        // Stall: 0x40+0x40 lands, then three stalled cycles with changing inputs.
        @(negedge AluClock);
        drive(8'h40, 8'h40, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("stall_pre", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, V_EN);
        for (int i = 0; i < 3; i++) begin
            @(negedge AluClock);
            drive(8'($urandom), 8'($urandom), 1'b1, 2'($urandom), 1'b1, i[0], 1'b1);
            tick();
            chk_all($sformatf("stall%0d", i), 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, V_EN);
        end
        @(negedge AluClock);
        drive(8'h01, 8'h02, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("stall_rel", 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle after a carrying add.
        @(negedge AluClock);
        drive(8'hFF, 8'h01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("rst_pre", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 nReset = 1'b0;
        #1;
        chk_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge AluClock);
        nReset = 1'b1;
        drive(8'h05, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("rst_post", 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the reference model.
        @(negedge AluClock);
        nReset = 1'b0;
        model_reset();
        #1 nReset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge AluClock);
            drive(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 4) == 0));
            if (i % 16 == 5) begin
                LHS = 8'h7F;
                Logic = 8'($urandom_range(0, 1));
            end
            model_edge();
            tick();
            chk_all($sformatf("rnd%0d", i), 8'(m_res), 1'(m_val), 1'(m_c), 1'(m_z),
                    1'(m_n), 1'(m_v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
